// File: rtl/ccc_bus_arbiter_if.sv
// Signal bundle between the CCC bus arbiter, its protocol handlers and the shared TX/RX engines.
interface ccc_bus_arbiter_if #(
  parameter int NumReq = 3
);
  logic [NumReq-1:0]   req_rx_bit_i;
  logic [NumReq-1:0]   req_rx_byte_i;
  logic [NumReq-1:0]   req_tx_bit_i;
  logic [NumReq-1:0]   req_tx_byte_i;
  logic [8*NumReq-1:0] req_tx_value_i;
  logic [NumReq-1:0]   req_tx_sel_od_pp_i;
  logic [NumReq-1:0]   req_lock_i;
  logic [NumReq-1:0]   rx_done_o;
  logic [NumReq-1:0]   tx_done_o;
  logic [7:0]          rx_data_o;
  logic [NumReq-1:0]   grant_o;
  logic                grant_valid_o;
  logic                protocol_err_o;
  logic                bus_rx_req_bit_o;
  logic                bus_rx_req_byte_o;
  logic [7:0]          bus_rx_data_i;
  logic                bus_rx_done_i;
  logic                bus_tx_req_bit_o;
  logic                bus_tx_req_byte_o;
  logic [7:0]          bus_tx_req_value_o;
  logic                bus_tx_sel_od_pp_o;
  logic                bus_tx_done_i;
  logic                bus_stop_det_i;

  // The arbiter sits on the slave side; handlers and bus engines drive the master side.
  modport slave (
    input  req_rx_bit_i, req_rx_byte_i, req_tx_bit_i, req_tx_byte_i,
    input  req_tx_value_i, req_tx_sel_od_pp_i, req_lock_i,
    input  bus_rx_data_i, bus_rx_done_i, bus_tx_done_i, bus_stop_det_i,
    output rx_done_o, tx_done_o, rx_data_o, grant_o, grant_valid_o, protocol_err_o,
    output bus_rx_req_bit_o, bus_rx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_byte_o,
    output bus_tx_req_value_o, bus_tx_sel_od_pp_o
  );

  modport master (
    output req_rx_bit_i, req_rx_byte_i, req_tx_bit_i, req_tx_byte_i,
    output req_tx_value_i, req_tx_sel_od_pp_i, req_lock_i,
    output bus_rx_data_i, bus_rx_done_i, bus_tx_done_i, bus_stop_det_i,
    input  rx_done_o, tx_done_o, rx_data_o, grant_o, grant_valid_o, protocol_err_o,
    input  bus_rx_req_bit_o, bus_rx_req_byte_o, bus_tx_req_bit_o, bus_tx_req_byte_o,
    input  bus_tx_req_value_o, bus_tx_sel_od_pp_o
  );
endinterface

// File: rtl/ccc_bus_arbiter.sv
// Round-robin arbiter sharing one TX/RX bit/byte engine among NumReq protocol handlers,
// with an optional per-handler lock that holds ownership across multi-transfer sequences.
module ccc_bus_arbiter #(
  parameter int NumReq = 3
) (
  input logic              clk_i,
  input logic              rst_ni,
  ccc_bus_arbiter_if.slave bus
);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {Idle, Busy, Held} state_e;

  state_e            state, next_state;
  logic [NumReq-1:0] grant, next_grant;
  logic [PtrW-1:0]   ptr, next_ptr;
  logic [PtrW-1:0]   owner, owner_inc, winner;
  logic [NumReq-1:0] req_any;
  logic              win_found;
  logic [3:0]        owner_reqs;
  logic              owner_any, owner_lock, any_done, release_now;
  int                cand;

  assign req_any = bus.req_rx_bit_i | bus.req_rx_byte_i | bus.req_tx_bit_i | bus.req_tx_byte_i;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) owner = PtrW'(i);
    end
  end

  assign owner_inc  = (owner == PtrW'(NumReq - 1)) ? '0 : owner + PtrW'(1);
  assign owner_reqs = {bus.req_tx_byte_i[owner], bus.req_tx_bit_i[owner],
                       bus.req_rx_byte_i[owner], bus.req_rx_bit_i[owner]};
  assign owner_any  = |owner_reqs;
  assign owner_lock = bus.req_lock_i[owner];
  assign any_done   = bus.bus_rx_done_i | bus.bus_tx_done_i;

  // Scan downward from ptr+NumReq-1 so the candidate closest to ptr is the last to win.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (req_any[cand]) begin
        winner    = PtrW'(cand);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    next_grant  = grant;
    next_ptr    = ptr;
    release_now = 1'b0;
    unique case (state)
      Idle: begin
        if (win_found) begin
          next_grant = {{(NumReq-1){1'b0}}, 1'b1} << winner;
          next_state = Busy;
        end
      end
      Busy: begin
        if (any_done || !owner_any) begin
          if (owner_lock) next_state = Held;
          else            release_now = 1'b1;
        end
      end
      Held: begin
        if (owner_any)        next_state = Busy;
        else if (!owner_lock) release_now = 1'b1;
      end
      default: next_state = Idle;
    endcase
    // A STOP on the bus ends any ownership, even a locked one.
    if (bus.bus_stop_det_i && state != Idle) release_now = 1'b1;
    if (bus.bus_stop_det_i) next_state = Idle;
    if (release_now) begin
      next_state = Idle;
      next_grant = '0;
      next_ptr   = owner_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= Idle;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= next_state;
      grant <= next_grant;
      ptr   <= next_ptr;
    end
  end

  // Only the owner's highest-priority request reaches the engines: tx_byte > tx_bit > rx_byte > rx_bit.
  always_comb begin
    bus.bus_tx_req_byte_o  = 1'b0;
    bus.bus_tx_req_bit_o   = 1'b0;
    bus.bus_rx_req_byte_o  = 1'b0;
    bus.bus_rx_req_bit_o   = 1'b0;
    bus.bus_tx_req_value_o = 8'h00;
    bus.bus_tx_sel_od_pp_o = 1'b0;
    bus.rx_done_o          = '0;
    bus.tx_done_o          = '0;
    bus.protocol_err_o     = 1'b0;
    if (state == Busy) begin
      if (owner_reqs[3])      bus.bus_tx_req_byte_o = 1'b1;
      else if (owner_reqs[2]) bus.bus_tx_req_bit_o  = 1'b1;
      else if (owner_reqs[1]) bus.bus_rx_req_byte_o = 1'b1;
      else if (owner_reqs[0]) bus.bus_rx_req_bit_o  = 1'b1;
      bus.bus_tx_req_value_o = bus.req_tx_value_i[8*owner +: 8];
      bus.bus_tx_sel_od_pp_o = bus.req_tx_sel_od_pp_i[owner];
      bus.rx_done_o          = grant & {NumReq{bus.bus_rx_done_i}};
      bus.tx_done_o          = grant & {NumReq{bus.bus_tx_done_i}};
      bus.protocol_err_o     = (owner_reqs & (owner_reqs - 4'd1)) != 4'd0;
    end
  end

  assign bus.rx_data_o     = bus.bus_rx_data_i;
  assign bus.grant_o       = grant;
  assign bus.grant_valid_o = (state != Idle);
endmodule

// File: tb/tb_ccc_bus_arbiter.sv
// Scoreboard bench for ccc_bus_arbiter: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_ccc_bus_arbiter;
  localparam int N = 3;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] obs;
  int          checks = 0;
  int          passes = 0;

  ccc_bus_arbiter_if #(.NumReq(N)) bif ();

  ccc_bus_arbiter #(.NumReq(N)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.req_rx_bit_i = '0;  bif.req_rx_byte_i = '0;
    bif.req_tx_bit_i = '0;  bif.req_tx_byte_i = '0;
    bif.req_tx_value_i = '0; bif.req_tx_sel_od_pp_i = '0; bif.req_lock_i = '0;
    bif.bus_rx_data_i = 8'h00; bif.bus_rx_done_i = 1'b0;
    bif.bus_tx_done_i = 1'b0;  bif.bus_stop_det_i = 1'b0;
    #2;
    exp_q.push_back('{"reset grant", 32'd0});
    exp_q.push_back('{"reset grant_valid", 32'd0});
    exp_q.push_back('{"reset bus reqs", 32'd0});
    exp_q.push_back('{"reset protocol_err", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.grant_valid_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front();
    obs = 32'({bif.bus_tx_req_byte_o, bif.bus_tx_req_bit_o, bif.bus_rx_req_byte_o, bif.bus_rx_req_bit_o});
    checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.protocol_err_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_grant();
    bif.req_tx_bit_i[1] = 1'b1;
    bif.req_tx_value_i[15:8] = 8'h01;
    #1;
    exp_q.push_back('{"no forward before grant", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_bit_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    exp_q.push_back('{"single grant", 32'h2});
    exp_q.push_back('{"single tx_bit fwd", 32'd1});
    exp_q.push_back('{"single tx value", 32'h01});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_bit_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_value_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.bus_tx_done_i = 1'b1;
    #1;
    exp_q.push_back('{"single tx_done routed", 32'h2});
    e = exp_q.pop_front(); obs = 32'(bif.tx_done_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    bif.bus_tx_done_i = 1'b0;
    bif.req_tx_bit_i[1] = 1'b0;
    #1;
    exp_q.push_back('{"single release", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    // Pointer now sits at 2, so 2 beats 0 when both ask.
    bif.req_rx_byte_i[0] = 1'b1;
    bif.req_rx_byte_i[2] = 1'b1;
    tick();
    exp_q.push_back('{"ptr after release", 32'h4});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.req_rx_byte_i = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    bif.req_rx_byte_i[0] = 1'b1;
    bif.req_rx_byte_i[2] = 1'b1;
    bif.bus_rx_data_i = 8'hFD;
    tick();
    exp_q.push_back('{"rr first grant", 32'h1});
    exp_q.push_back('{"rr rx_byte fwd", 32'd1});
    exp_q.push_back('{"rr rx_data", 32'hFD});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.bus_rx_req_byte_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.rx_data_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.bus_rx_done_i = 1'b1;
    #1;
    exp_q.push_back('{"rr rx_done to 0", 32'h1});
    e = exp_q.pop_front(); obs = 32'(bif.rx_done_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    bif.bus_rx_done_i = 1'b0;
    bif.req_rx_byte_i[0] = 1'b0;
    #1;
    exp_q.push_back('{"rr idle gap", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    exp_q.push_back('{"rr second grant", 32'h4});
    exp_q.push_back('{"rr rx_data second", 32'hFD});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.rx_data_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.bus_rx_done_i = 1'b1;
    #1;
    exp_q.push_back('{"rr rx_done to 2", 32'h4});
    e = exp_q.pop_front(); obs = 32'(bif.rx_done_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    bif.bus_rx_done_i = 1'b0;
    bif.req_rx_byte_i = '0;
    tick();
  endtask

  task automatic test_lock();
    bif.req_tx_bit_i[0] = 1'b1;
    bif.req_lock_i[0]   = 1'b1;
    bif.req_tx_bit_i[1] = 1'b1;
    tick();
    for (int i = 0; i < 65; i++) begin
      exp_q.push_back('{"lock busy grant", 32'h1});
      exp_q.push_back('{"lock busy tx_bit", 32'd1});
      e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
      if (obs !== e.val) $display("[TB] FAIL %s bit %0d: observed %0h required %0h", e.name, i, obs, e.val); else passes++;
      e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_bit_o); checks++;
      if (obs !== e.val) $display("[TB] FAIL %s bit %0d: observed %0h required %0h", e.name, i, obs, e.val); else passes++;
      bif.bus_tx_done_i = 1'b1;
      tick();
      bif.bus_tx_done_i = 1'b0;
      #1;
      exp_q.push_back('{"lock held grant", 32'h1});
      exp_q.push_back('{"lock held quiet", 32'd0});
      e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
      if (obs !== e.val) $display("[TB] FAIL %s bit %0d: observed %0h required %0h", e.name, i, obs, e.val); else passes++;
      e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_bit_o); checks++;
      if (obs !== e.val) $display("[TB] FAIL %s bit %0d: observed %0h required %0h", e.name, i, obs, e.val); else passes++;
      tick();
    end
    bif.req_tx_bit_i[0] = 1'b0;
    bif.req_lock_i[0]   = 1'b0;
    tick();
    exp_q.push_back('{"lock release", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    exp_q.push_back('{"lock waiter granted", 32'h2});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.req_tx_bit_i[1] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stop();
    bif.req_tx_byte_i[0] = 1'b1;
    bif.req_lock_i[0]    = 1'b1;
    bif.req_tx_value_i[7:0] = 8'hA5;
    tick();
    exp_q.push_back('{"stop grant", 32'h1});
    exp_q.push_back('{"stop tx value", 32'hA5});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_value_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.bus_stop_det_i = 1'b1;
    bif.bus_tx_done_i  = 1'b1;
    #1;
    exp_q.push_back('{"stop done routed", 32'h1});
    e = exp_q.pop_front(); obs = 32'(bif.tx_done_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    bif.bus_stop_det_i = 1'b0;
    bif.bus_tx_done_i  = 1'b0;
    bif.req_tx_byte_i[0] = 1'b0;
    bif.req_lock_i[0]    = 1'b0;
    #1;
    exp_q.push_back('{"stop grant cleared", 32'd0});
    exp_q.push_back('{"stop grant_valid", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.grant_valid_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
  endtask

  task automatic test_protocol_err();
    bif.req_tx_byte_i[0] = 1'b1;
    bif.req_rx_bit_i[0]  = 1'b1;
    tick();
    exp_q.push_back('{"perr tx_byte fwd", 32'd1});
    exp_q.push_back('{"perr rx_bit blocked", 32'd0});
    exp_q.push_back('{"perr pulse", 32'd1});
    e = exp_q.pop_front(); obs = 32'(bif.bus_tx_req_byte_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.bus_rx_req_bit_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.protocol_err_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.req_tx_byte_i[0] = 1'b0;
    bif.req_rx_bit_i[0]  = 1'b0;
    #1;
    exp_q.push_back('{"perr cleared", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.protocol_err_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bif.req_rx_bit_i[2] = 1'b1;
    tick();
    exp_q.push_back('{"mid rx_bit fwd", 32'd1});
    e = exp_q.pop_front(); obs = 32'(bif.bus_rx_req_bit_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    rst_n = 1'b0;
    bif.bus_rx_done_i = 1'b1;
    #1;
    exp_q.push_back('{"mid reset grant", 32'd0});
    exp_q.push_back('{"mid reset grant_valid", 32'd0});
    exp_q.push_back('{"mid reset rx_bit", 32'd0});
    exp_q.push_back('{"mid reset rx_done", 32'd0});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.grant_valid_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.bus_rx_req_bit_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    e = exp_q.pop_front(); obs = 32'(bif.rx_done_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    tick();
    rst_n = 1'b1;
    bif.bus_rx_done_i = 1'b0;
    bif.req_rx_bit_i = 3'b011;
    // Pointer was 1 before reset; a cleared pointer hands the bus to 0.
    tick();
    exp_q.push_back('{"ptr cleared by reset", 32'h1});
    e = exp_q.pop_front(); obs = 32'(bif.grant_o); checks++;
    if (obs !== e.val) $display("[TB] FAIL %s: observed %0h required %0h", e.name, obs, e.val); else passes++;
    bif.req_rx_bit_i = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_lock();
    test_stop();
    test_protocol_err();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ccc_bus_arbiter.md
Name: ccc_bus_arbiter

Overview:
- Shares the single bus TX/RX bit/byte engine between NumReq protocol handlers.
- Handlers include the ENTDAA handler, the direct/broadcast CCC handler and the private-transfer FSM.
- Grants one owner at a time using round-robin, forwards only the owner's requests to the bus engines, and routes done pulses back to the owner.
- An optional lock input lets a handler keep ownership across a multi-transfer sequence, for example the 64 ID bits plus address phase of ENTDAA.

Parameters:
NumReq, 3, number of requesters (2..8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_rx_bit_i  in  NumReq  per-requester RX bit request (level)
req_rx_byte_i  in  NumReq  per-requester RX byte request (level)
req_tx_bit_i  in  NumReq  per-requester TX bit request (level)
req_tx_byte_i  in  NumReq  per-requester TX byte request (level)
req_tx_value_i  in  8*NumReq  per-requester TX value; slice i = [8*i+7:8*i]
req_tx_sel_od_pp_i  in  NumReq  per-requester open-drain/push-pull select
req_lock_i  in  NumReq  hold grant across gaps between transfers
rx_done_o  out  NumReq  RX done pulse, owner only
tx_done_o  out  NumReq  TX done pulse, owner only
rx_data_o  out  8  bus_rx_data_i passthrough to all requesters
grant_o  out  NumReq  registered one-hot owner
grant_valid_o  out  1  state != Idle
protocol_err_o  out  1  one-cycle pulse: owner asserted more than one request type
bus_rx_req_bit_o  out  1  to RX engine
bus_rx_req_byte_o  out  1  to RX engine
bus_rx_data_i  in  8  from RX engine
bus_rx_done_i  in  1  from RX engine, one-cycle pulse
bus_tx_req_bit_o  out  1  to TX engine
bus_tx_req_byte_o  out  1  to TX engine
bus_tx_req_value_o  out  8  to TX engine
bus_tx_sel_od_pp_o  out  1  to TX engine
bus_tx_done_i  in  1  from TX engine, one-cycle pulse
bus_stop_det_i  in  1  STOP detected by bus monitor

Behaviour:
- Reset values:
  - State = Idle; grant_o = 0; round-robin pointer ptr = 0.
  - All bus_* outputs, done outputs and protocol_err_o = 0.
- req_any[i] is the OR of requester i's four request lines.
- States: Idle, Busy, Held.
- Idle:
  - If any req_any is set, the winner is the first i with req_any[i] set, searching ptr, ptr+1, ... modulo NumReq.
  - grant_o <= onehot(winner); next state = Busy.
  - Grant latency is 1 cycle: the request is first forwarded to the bus engines in the cycle after it is asserted from Idle.
  - Bus outputs are 0 while in Idle.
- Busy:
  - Owner requests are forwarded combinationally to the bus engines.
  - If the owner asserts multiple request types, only the highest priority is forwarded: tx_byte > tx_bit > rx_byte > rx_bit. protocol_err_o pulses in every such cycle.
  - bus_tx_req_value_o and bus_tx_sel_od_pp_o always come from the owner's slice.
  - bus_rx_done_i routes to rx_done_o[owner] and bus_tx_done_i routes to tx_done_o[owner], in the same cycle (combinational). Non-owners never receive done.
  - On any done: next state = Held if req_lock_i[owner], else Idle.
  - If the owner drops all requests without a done (abort): next state = Held if locked, else Idle.
- Held:
  - Bus outputs are 0; grant is kept; other requesters are ignored.
  - If req_any[owner] is set: next state = Busy, and forwarding starts the next cycle.
  - Else if !req_lock_i[owner]: next state = Idle.
- Release (any transition to Idle):
  - grant_o <= 0; ptr <= (owner+1) mod NumReq.
  - A new arbitration happens only from Idle, so there is at least one Idle cycle between owners.
- bus_stop_det_i:
  - From any state, next state = Idle with release semantics; lock is overridden.
  - A done pulse arriving in the same cycle is still routed to the owner.
- Done pulses received in Idle or Held are dropped.
- Simultaneous rx and tx done: both are routed; a single release/hold decision is made.

Test Plan:
- Requester 1 alone asserts req_tx_bit, value=8'h01 -> grant_o=3'b010 after 1 cycle; bus_tx_req_bit_o=1, value 8'h01; bus_tx_done_i -> tx_done_o=3'b010; back to Idle, ptr=2.
- Requesters 0 and 2 assert rx_byte in the same cycle with ptr=0 -> 0 granted first; after done, 2 granted following one Idle cycle; rx_data_o=8'hFD visible to both.
- Requester 0 sets lock and performs 65 TX bits with 1-cycle gaps while requester 1 requests -> 1 never granted until lock drops; grant_o stays 3'b001 throughout.
- bus_stop_det_i during Busy with lock set -> Idle next cycle; grant_o=0; pending tx_done coincident with the STOP still reaches the owner.
- Owner asserts tx_byte and rx_bit together -> only bus_tx_req_byte_o=1 is forwarded; protocol_err_o=1 in that cycle.
- Assert rst_ni low mid-Busy -> all outputs 0 and ptr=0 immediately; no done pulses emitted.
